// File: rtl/mixer_pkg.sv
// Shared definitions for the multi-ingredient mixer.
// Contents:
//   state_t           - controller state encoding
//   FAULT_* constants - values presented on fault_code
package mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_MIX,
        ST_DRAIN,
        ST_DONE,
        ST_FAULT,
        ST_ESTOP
    } state_t;

    localparam logic [1:0] FAULT_NONE         = 2'b00;
    localparam logic [1:0] FAULT_FILL_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_ESTOP        = 2'b10;

endpackage

// File: rtl/counter.sv
// Generic loadable up/down counter that saturates at either end.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   load          - load load_value (takes priority over enable)
//   enable        - count one step in the selected direction
//   direction     - 1 counts up, 0 counts down
//   load_value    - value loaded when load is high
//   counter_done  - high when the count sits at its saturation limit
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic             direction,
    input  logic [WIDTH-1:0] load_value,
    output logic             counter_done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            if (direction) begin
                if (count != '1) count <= count + WIDTH'(1);
            end else begin
                if (count != '0) count <= count - WIDTH'(1);
            end
        end
    end

    assign counter_done = direction ? (count == '1) : (count == '0);

endmodule

// File: rtl/multi_ingredient_mixer.sv
// Batch mixer controller: fills each selected ingredient in ascending order,
// mixes, drains, then pulses done. Fill timeout and emergency stop lead to
// FAULT/ESTOP, both cleared by ack.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   start                     - batch request (only honoured in IDLE)
//   recipe_mask               - ingredients used by the batch
//   level                     - per-ingredient level-reached sensors
//   empty                     - tank empty sensor
//   estop, ack                - emergency stop, operator clear
//   mix_time, drain_time,
//   fill_timeout              - durations in cycles, latched on start
//   valve, drain, mixer       - actuators
//   busy, done, fault_code    - status
//   step                      - index of the ingredient being filled
module multi_ingredient_mixer
    import mixer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_ING = 4,
    localparam int STEP_W = (N_ING > 1) ? $clog2(N_ING) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_ING-1:0]  recipe_mask,
    input  logic [N_ING-1:0]  level,
    input  logic              empty,
    input  logic              estop,
    input  logic              ack,
    input  logic [WIDTH-1:0]  mix_time,
    input  logic [WIDTH-1:0]  drain_time,
    input  logic [WIDTH-1:0]  fill_timeout,
    output logic [N_ING-1:0]  valve,
    output logic              drain,
    output logic              mixer,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fault_code,
    output logic [STEP_W-1:0] step
);

    state_t              state, state_n;
    logic [STEP_W-1:0]   step_n;
    logic [N_ING-1:0]    mask_q;
    logic [WIDTH-1:0]    mix_q, drain_q, fill_q;
    logic                latch_cfg;

    logic                tmr_load, tmr_en, tmr_done;
    logic [WIDTH-1:0]    tmr_val;

    logic                first_found, next_found;
    logic [STEP_W-1:0]   first_idx, next_idx;

    // The timer is loaded with duration-1 and the state exits when it reads
    // zero, so a state lasts max(duration,1) cycles.
    function automatic logic [WIDTH-1:0] dur_to_load(input logic [WIDTH-1:0] d);
        return (d == '0) ? '0 : d - WIDTH'(1);
    endfunction

    counter #(.WIDTH(WIDTH)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load         (tmr_load),
        .enable       (tmr_en),
        .direction    (1'b0),
        .load_value   (tmr_val),
        .counter_done (tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            step    <= '0;
            mask_q  <= '0;
            mix_q   <= '0;
            drain_q <= '0;
            fill_q  <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            if (latch_cfg) begin
                mask_q  <= recipe_mask;
                mix_q   <= mix_time;
                drain_q <= drain_time;
                fill_q  <= fill_timeout;
            end
        end
    end

    // Priority searches: the lowest set bit of the incoming mask selects the
    // first ingredient; the lowest latched bit above step selects the next.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = N_ING - 1; i >= 0; i--) begin
            if (recipe_mask[i]) begin
                first_found = 1'b1;
                first_idx   = STEP_W'(i);
            end
            if (mask_q[i] && (i > int'(step))) begin
                next_found = 1'b1;
                next_idx   = STEP_W'(i);
            end
        end
    end

    // Next-state logic. The timer is loaded on the transition edge so it
    // already holds the new duration in the first cycle of a state or step.
    // In IDLE the durations come straight from the ports because the latch
    // happens on the same edge.
    always_comb begin
        state_n   = state;
        step_n    = step;
        latch_cfg = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = '0;
        if (estop) begin
            state_n = ST_ESTOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        latch_cfg = 1'b1;
                        tmr_load  = 1'b1;
                        if (first_found) begin
                            state_n = ST_FILL;
                            step_n  = first_idx;
                            tmr_val = dur_to_load(fill_timeout);
                        end else begin
                            state_n = ST_MIX;
                            tmr_val = dur_to_load(mix_time);
                        end
                    end
                end
                ST_FILL: begin
                    // A level hit wins over a simultaneous timeout.
                    if (level[step]) begin
                        tmr_load = 1'b1;
                        if (next_found) begin
                            step_n  = next_idx;
                            tmr_val = dur_to_load(fill_q);
                        end else begin
                            state_n = ST_MIX;
                            tmr_val = dur_to_load(mix_q);
                        end
                    end else if (tmr_done) begin
                        state_n = ST_FAULT;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_MIX: begin
                    if (tmr_done) begin
                        state_n  = ST_DRAIN;
                        tmr_load = 1'b1;
                        tmr_val  = dur_to_load(drain_q);
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (tmr_done && empty) state_n = ST_DONE;
                    else                   tmr_en  = 1'b1;
                end
                ST_DONE:  state_n = ST_IDLE;
                ST_FAULT: if (ack) state_n = ST_IDLE;
                ST_ESTOP: if (ack) state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // Moore output decode from the state and step registers.
    always_comb begin
        valve = '0;
        for (int i = 0; i < N_ING; i++) begin
            valve[i] = (state == ST_FILL) && (step == STEP_W'(i));
        end
        mixer = (state == ST_MIX);
        drain = (state == ST_DRAIN);
        busy  = (state == ST_FILL) || (state == ST_MIX) || (state == ST_DRAIN);
        done  = (state == ST_DONE);
        case (state)
            ST_FAULT: fault_code = FAULT_FILL_TIMEOUT;
            ST_ESTOP: fault_code = FAULT_ESTOP;
            default:  fault_code = FAULT_NONE;
        endcase
    end

endmodule
